// File: rtl/inst_encoder.sv
// RV32I field-to-instruction assembler with word-address tagging.
// Illegal bundles are dropped and counted; one-entry output register.
module inst_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [7:0]        err_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [7:0]          ecnt_q, ecnt_d;

    logic                legal;
    logic [31:0]         enc;
    logic signed [31:0]  simm;
    logic                accept;
    logic [ADDR_W-1:0]   tag;
    logic                imm12_ok;
    logic                f7_rok;

    assign simm      = imm;
    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign err_illegal = err_q;
    assign err_cnt   = ecnt_q;

    assign imm12_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign f7_rok   = (funct7 == 7'd0) || (funct7 == F7_ALT);

    // Pack fields into the instruction word and judge legality.
    always_comb begin
        legal = 1'b0;
        enc   = 32'd0;
        unique case (opcode)
            OP_R: begin
                legal = f7_rok;
                enc   = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            OP_I: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    legal = (imm[31:5] == 27'd0) &&
                            ((funct7 == 7'd0) ||
                             (funct3 == 3'b101 && funct7 == F7_ALT));
                    enc   = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                end else begin
                    legal = imm12_ok;
                    enc   = {imm[11:0], rs1, funct3, rd, opcode};
                end
            end
            OP_L, OP_JALR: begin
                legal = imm12_ok;
                enc   = {imm[11:0], rs1, funct3, rd, opcode};
            end
            OP_S: begin
                legal = imm12_ok;
                enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            OP_B: begin
                legal = (simm >= -32'sd4096) && (simm <= 32'sd4094) &&
                        !imm[0];
                enc   = {imm[12], imm[10:5], rs2, rs1, funct3,
                         imm[4:1], imm[11], opcode};
            end
            OP_LUI, OP_AUIPC: begin
                legal = (imm[11:0] == 12'd0);
                enc   = {imm[31:12], rd, opcode};
            end
            OP_JAL: begin
                legal = (simm >= -32'sd1048576) &&
                        (simm <= 32'sd1048574) && !imm[0];
                enc   = {imm[20], imm[10:1], imm[11], imm[19:12],
                         rd, opcode};
            end
            default: begin
                legal = 1'b0;
                enc   = 32'd0;
            end
        endcase
    end

    // Output register FSM, address counter and error bookkeeping.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ecnt_d  = ecnt_q;
        tag     = addr_clr ? BASE : cnt_q;
        if (addr_clr) begin
            cnt_d = BASE;
        end
        if (accept && legal) begin
            instr_d = enc;
            addr_d  = tag;
            cnt_d   = tag + ADDR_W'(1);
            state_d = FULL;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
        if (accept && !legal) begin
            err_d = 1'b1;
            if (ecnt_q != 8'hFF) begin
                ecnt_d = ecnt_q + 8'd1;
            end
        end
    end

    // State update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            instr_q <= 32'd0;
            addr_q  <= '0;
            cnt_q   <= BASE;
            err_q   <= 1'b0;
            ecnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
        end
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Field-to-encoding assembler for the RV32I core's instruction-load path. It accepts one decoded-field bundle per handshake (opcode, funct3, funct7, rd, rs1, rs2, 32-bit immediate) and emits the canonical 32-bit RV32I instruction word, tagged with a sequential instruction-memory word address. It also range-checks every field, drops illegal bundles, and flags them. It sits between the test/boot program source and the instruction-memory write port, and is the exact inverse of the core's decode stage.

## Interface
Parameters:
- ADDR_W, 10, width of the word-address counter and `out_addr`
- BASE_ADDR, 0, counter value after reset or `addr_clr`

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept the bundle this cycle
- opcode  input  7  encodings per `OPCODE_*` in define.vh
- funct3  input  3  funct3 field
- funct7  input  7  used by R-type and by I-type shifts only
- rd, rs1, rs2  input  5 each  register indices
- imm  input  32  signed byte-offset or value, not pre-shifted (LUI/AUIPC: full 32-bit value)
- addr_clr  input  1  reload the address counter with BASE_ADDR
- out_valid  output  1  `out_instr`/`out_addr` valid
- out_ready  input  1  sink accepts output
- out_instr  output  32  encoded instruction
- out_addr  output  ADDR_W  word address assigned to `out_instr`
- err_illegal  output  1  sticky; set on any dropped bundle
- err_cnt  output  8  count of dropped bundles, saturates at 255

## Operation
- Supported formats (standard RV32I bit placement):
  - R (0110011)
  - I-ALU (0010011)
  - L (0000011)
  - JALR (1100111)
  - S (0100011)
  - B (1100011)
  - LUI (0110111)
  - AUIPC (0010111)
  - JAL (1101111)
- Format packing:
  - I/L/JALR: imm[11:0] goes to [31:20].
  - S: imm[11:5] goes to [31:25]; imm[4:0] goes to [11:7].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: imm[31:12] goes to [31:12].
  - I-shift (funct3 001/101): [31:25]=funct7, [24:20]=imm[4:0].
- Unused fields per format are ignored and contribute nothing to the output word.
- Legality checks; any failure makes the bundle illegal:
  - Opcode is unsupported.
  - I/L/S/JALR: imm is outside [-2048, 2047].
  - B: imm is outside [-4096, 4094], or imm[0] is 1.
  - J: imm is outside [-2^20, 2^20-2], or imm[0] is 1.
  - LUI/AUIPC: imm[11:0] is not 0.
  - Shift: imm is outside [0, 31]; funct7 is not 0000000 for funct3 001; funct7 is not 0000000 or 0100000 for funct3 101.
  - R-type: funct7 is not 0000000 or 0100000.
- Acceptance: a bundle is accepted when `in_valid && in_ready`.
  - Legal bundle: loaded into the output register with `out_addr` = current counter. Counter then increments modulo 2^ADDR_W (wraps from 2^ADDR_W-1 to 0, not to BASE_ADDR).
  - Illegal bundle: consumed, with no output and no counter change. `err_illegal` is set to 1; `err_cnt` increments unless it is already 255.
- `addr_clr` has priority over the same-cycle increment.
  - A bundle accepted in the same cycle is tagged BASE_ADDR.
  - The counter then becomes BASE_ADDR+1.
- Output register states: EMPTY and FULL.
  - EMPTY to FULL on a legal accept.
  - FULL to EMPTY on `out_valid && out_ready` with no legal accept.
  - FULL stays FULL on a simultaneous drain and legal accept.

## Timing
- Encode latency is 1 cycle: a bundle accepted at edge N appears on `out_*` after edge N.
- `in_ready = !out_valid || out_ready` (combinational from `out_ready`). This gives full throughput of one instruction per cycle.
- While `out_valid` is 1, `out_instr` and `out_addr` stay stable until accepted.
- Illegal bundles are always consumed in one cycle when `in_ready` is 1.
- Reset values:
  - `out_valid` = 0, `out_instr` = 0, `out_addr` = 0
  - counter = BASE_ADDR
  - `err_illegal` = 0, `err_cnt` = 0
- Reset mid-stream discards any held instruction; there is no partial output.
- `err_illegal` and `err_cnt` clear only on `rst`.

## Test plan
- Legal encodes, each -> value on `out_instr` one cycle later, with addresses 0..5:
  - addi x1,x0,5 -> 0x00500093
  - sub x3,x1,x2 -> 0x402081B3
  - sw x2,8(x1) -> 0x0020A423
  - beq x1,x2,imm=-4 -> 0xFE208EE3
  - jal x1,imm=2048 -> 0x001000EF
  - lui x5,imm=0x12345000 -> 0x123452B7
- Backpressure:
  - `out_ready`=0, two back-to-back bundles -> first held stable, `in_ready`=0, second not taken.
  - Raising `out_ready` -> both delivered in order with addresses 0,1.
- Illegal drops:
  - B imm=3 -> no output, `err_illegal`=1, `err_cnt`=1, counter unchanged.
  - 300 illegal bundles -> `err_cnt`=255.
- Counter wrap and clear:
  - ADDR_W=2 with 5 legal bundles -> `out_addr` 0,1,2,3,0.
  - `addr_clr` concurrent with an accept -> that instruction tagged BASE_ADDR, next tagged BASE_ADDR+1.
- Reset while FULL -> `out_valid`=0 the next cycle; next accepted bundle tagged BASE_ADDR.
